// File: rtl/core_mem_arb_pkg.sv
// Shared types for the IFU/LSU memory-port arbiter: FSM states, owner codes
// and grant-vector bit positions.
package core_mem_arb_pkg;

    localparam int CORE_MARB_AW = 32;
    localparam int CORE_MARB_DW = 64;
    localparam int CORE_MARB_MW = CORE_MARB_DW / 8;

    typedef enum logic [1:0] {
        CORE_MARB_IDLE = 2'd0,
        CORE_MARB_REQ  = 2'd1,
        CORE_MARB_RSP  = 2'd2
    } marb_state_e;

    typedef enum logic {
        CORE_MARB_OWN_IFU = 1'b0,
        CORE_MARB_OWN_LSU = 1'b1
    } marb_owner_e;

    // Bit positions inside the one-hot grant vector.
    localparam int GNT_IFU = 0;
    localparam int GNT_LSU = 1;

endpackage

// File: rtl/core_mem_arb_if.sv
// Bundle of IFU, LSU and memory-side handshake signals around the arbiter.
// The arbiter uses the slave view; requesters and memory use the master view.
interface core_mem_arb_if #(
    parameter int AW = 32,
    parameter int DW = 64,
    parameter int MW = DW / 8
);
    logic          ifu_req_valid;
    logic          ifu_req_ready;
    logic [AW-1:0] ifu_req_addr;
    logic          ifu_flush;
    logic          ifu_rsp_valid;
    logic [DW-1:0] ifu_rsp_data;

    logic          lsu_req_valid;
    logic          lsu_req_ready;
    logic [AW-1:0] lsu_req_addr;
    logic          lsu_req_wen;
    logic [DW-1:0] lsu_req_wdata;
    logic [MW-1:0] lsu_req_wmask;
    logic          lsu_rsp_valid;
    logic [DW-1:0] lsu_rsp_data;

    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_wen;
    logic [DW-1:0] mem_req_wdata;
    logic [MW-1:0] mem_req_wmask;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rsp_data;

    modport slave (
        input  ifu_req_valid, ifu_req_addr, ifu_flush,
        input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
        output lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask
    );

    modport master (
        output ifu_req_valid, ifu_req_addr, ifu_flush,
        output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask
    );

endinterface

// File: rtl/core_mem_arb_rr.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to whichever
// requester did not win last time.
module core_mem_arb_rr
    import core_mem_arb_pkg::*;
(
    input  logic        ifu_valid,
    input  logic        lsu_valid,
    input  marb_owner_e rr_last,
    output logic [1:0]  grant
);

    always_comb begin
        grant = 2'b00;
        if (ifu_valid && lsu_valid) begin
            if (rr_last == CORE_MARB_OWN_IFU) begin
                grant[GNT_LSU] = 1'b1;
            end else begin
                grant[GNT_IFU] = 1'b1;
            end
        end else if (ifu_valid) begin
            grant[GNT_IFU] = 1'b1;
        end else if (lsu_valid) begin
            grant[GNT_LSU] = 1'b1;
        end
    end

endmodule

// File: rtl/core_mem_arb.sv
// Shares one memory port between instruction fetch and load/store, one
// transaction in flight, and discards fetch responses killed by a flush.
module core_mem_arb
    import core_mem_arb_pkg::*;
#(
    parameter int AW = CORE_MARB_AW,
    parameter int DW = CORE_MARB_DW,
    parameter int MW = DW / 8
) (
    input  logic          clk,
    input  logic          rst,
    core_mem_arb_if.slave bus,
    output logic          arb_busy
);

    marb_state_e   state_q, state_d;
    marb_owner_e   owner_q, owner_d;
    marb_owner_e   rr_last_q, rr_last_d;
    logic          drop_q, drop_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          wen_q, wen_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [MW-1:0] wmask_q, wmask_d;

    logic          ifu_cand;
    logic [1:0]    grant;
    logic          ifu_ready, lsu_ready, ifu_rsp, lsu_rsp;

    // A flushed fetch never competes for the port.
    assign ifu_cand = bus.ifu_req_valid & ~bus.ifu_flush;

    core_mem_arb_rr u_rr (
        .ifu_valid (ifu_cand),
        .lsu_valid (bus.lsu_req_valid),
        .rr_last   (rr_last_q),
        .grant     (grant)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch can infer a latch.
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        drop_d    = drop_q;
        addr_d    = addr_q;
        wen_d     = wen_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        ifu_ready = 1'b0;
        lsu_ready = 1'b0;
        ifu_rsp   = 1'b0;
        lsu_rsp   = 1'b0;

        unique case (state_q)
            CORE_MARB_IDLE: begin
                ifu_ready = grant[GNT_IFU];
                lsu_ready = grant[GNT_LSU];
                if (grant[GNT_IFU]) begin
                    state_d   = CORE_MARB_REQ;
                    owner_d   = CORE_MARB_OWN_IFU;
                    rr_last_d = CORE_MARB_OWN_IFU;
                    drop_d    = 1'b0;
                    addr_d    = bus.ifu_req_addr;
                    wen_d     = 1'b0;
                    wdata_d   = '0;
                    wmask_d   = '0;
                end else if (grant[GNT_LSU]) begin
                    state_d   = CORE_MARB_REQ;
                    owner_d   = CORE_MARB_OWN_LSU;
                    rr_last_d = CORE_MARB_OWN_LSU;
                    drop_d    = 1'b0;
                    addr_d    = bus.lsu_req_addr;
                    wen_d     = bus.lsu_req_wen;
                    wdata_d   = bus.lsu_req_wdata;
                    wmask_d   = bus.lsu_req_wmask;
                end
            end
            CORE_MARB_REQ: begin
                if (bus.mem_req_ready) begin
                    state_d = CORE_MARB_RSP;
                end
            end
            CORE_MARB_RSP: begin
                if (bus.mem_rsp_valid) begin
                    state_d = CORE_MARB_IDLE;
                    ifu_rsp = (owner_q == CORE_MARB_OWN_IFU) && !drop_q && !bus.ifu_flush;
                    lsu_rsp = (owner_q == CORE_MARB_OWN_LSU);
                end
            end
            default: state_d = CORE_MARB_IDLE;
        endcase

        // The memory side still completes; only the IFU response is swallowed.
        if ((state_q != CORE_MARB_IDLE) && (owner_q == CORE_MARB_OWN_IFU) && bus.ifu_flush) begin
            drop_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CORE_MARB_IDLE;
            owner_q   <= CORE_MARB_OWN_IFU;
            rr_last_q <= CORE_MARB_OWN_IFU;
            drop_q    <= 1'b0;
            // NOTE: the latched request fields drive ports directly, so they are reset to keep outputs at 0.
            addr_q    <= '0;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
            wmask_q   <= '0;
        end else begin
            // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            drop_q    <= drop_d;
            addr_q    <= addr_d;
            wen_q     <= wen_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
        end
    end

    // Combinational handshakes are held low while reset is applied.
    assign bus.ifu_req_ready = ifu_ready & ~rst;
    assign bus.lsu_req_ready = lsu_ready & ~rst;
    assign bus.ifu_rsp_valid = ifu_rsp & ~rst;
    assign bus.lsu_rsp_valid = lsu_rsp & ~rst;
    assign bus.ifu_rsp_data  = (ifu_rsp & ~rst) ? bus.mem_rsp_data : '0;
    assign bus.lsu_rsp_data  = (lsu_rsp & ~rst) ? bus.mem_rsp_data : '0;

    assign bus.mem_req_valid = (state_q == CORE_MARB_REQ) & ~rst;
    assign bus.mem_req_addr  = addr_q;
    assign bus.mem_req_wen   = wen_q;
    assign bus.mem_req_wdata = wdata_q;
    assign bus.mem_req_wmask = wmask_q;

    assign arb_busy = (state_q != CORE_MARB_IDLE) & ~rst;

endmodule

// File: tb/tb_core_mem_arb.sv
// Self-checking bench for core_mem_arb: directed scenarios then random traffic,
// all compared cycle by cycle against a transaction-level reference model.
module tb_core_mem_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic arb_busy;

    core_mem_arb_if #(.AW(32), .DW(64), .MW(8)) bus ();

    core_mem_arb dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .arb_busy (arb_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        iv;
        logic [31:0] ia;
        logic        fl;
        logic        lv;
        logic [31:0] la;
        logic        lw;
        logic [63:0] lwd;
        logic [7:0]  lwm;
        logic        mrdy;
        logic        mrv;
        logic [63:0] mrd;
    } stim_t;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: one transaction record plus the round-robin history.
    bit          m_busy, m_sent, m_lsu, m_killed, m_last_lsu;
    logic [31:0] m_addr;
    logic        m_wen;
    logic [63:0] m_wdata;
    logic [7:0]  m_wmask;

    logic [1:0]  grant_log[$];
    int          ifu_rsp_cnt, lsu_rsp_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic stim_t quiet();
        stim_t s;
        s.r = 1'b0; s.iv = 1'b0; s.ia = '0; s.fl = 1'b0;
        s.lv = 1'b0; s.la = '0; s.lw = 1'b0; s.lwd = '0; s.lwm = '0;
        s.mrdy = 1'b0; s.mrv = 1'b0; s.mrd = '0;
        return s;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_sent = 0; m_lsu = 0; m_killed = 0; m_last_lsu = 0;
        m_addr = '0; m_wen = 1'b0; m_wdata = '0; m_wmask = '0;
    endtask

    // One clock: drive, compare outputs with the model, then advance the model.
    task automatic step(input stim_t s);
        bit cand, e_ir, e_lr, e_irv, e_lrv;
        @(posedge clk);
        #2;
        rst                = s.r;
        bus.ifu_req_valid  = s.iv;
        bus.ifu_req_addr   = s.ia;
        bus.ifu_flush      = s.fl;
        bus.lsu_req_valid  = s.lv;
        bus.lsu_req_addr   = s.la;
        bus.lsu_req_wen    = s.lw;
        bus.lsu_req_wdata  = s.lwd;
        bus.lsu_req_wmask  = s.lwm;
        bus.mem_req_ready  = s.mrdy;
        bus.mem_rsp_valid  = s.mrv;
        bus.mem_rsp_data   = s.mrd;
        #2;
        cand  = s.iv && !s.fl;
        e_ir  = !m_busy && cand && (!s.lv || m_last_lsu);
        e_lr  = !m_busy && s.lv && (!cand || !m_last_lsu);
        e_irv = m_busy && m_sent && s.mrv && !m_lsu && !m_killed && !s.fl;
        e_lrv = m_busy && m_sent && s.mrv && m_lsu;
        if (!s.r) begin
            check("ifu_req_ready", bus.ifu_req_ready, e_ir);
            check("lsu_req_ready", bus.lsu_req_ready, e_lr);
            check("mem_req_valid", bus.mem_req_valid, m_busy && !m_sent);
            check("mem_req_addr",  bus.mem_req_addr,  m_addr);
            check("mem_req_wen",   bus.mem_req_wen,   m_wen);
            check("mem_req_wdata", bus.mem_req_wdata, m_wdata);
            check("mem_req_wmask", bus.mem_req_wmask, m_wmask);
            check("ifu_rsp_valid", bus.ifu_rsp_valid, e_irv);
            check("lsu_rsp_valid", bus.lsu_rsp_valid, e_lrv);
            check("arb_busy",      arb_busy,          m_busy);
            if (e_irv) check("ifu_rsp_data", bus.ifu_rsp_data, s.mrd);
            if (e_lrv && !m_wen) check("lsu_rsp_data", bus.lsu_rsp_data, s.mrd);
            if (bus.ifu_req_ready || bus.lsu_req_ready)
                grant_log.push_back({bus.lsu_req_ready, bus.ifu_req_ready});
            if (bus.ifu_rsp_valid) ifu_rsp_cnt++;
            if (bus.lsu_rsp_valid) lsu_rsp_cnt++;
        end
        if (s.r) begin
            model_reset();
        end else begin
            if (m_busy && !m_lsu && s.fl) m_killed = 1;
            if (!m_busy) begin
                if (e_ir) begin
                    m_busy = 1; m_sent = 0; m_lsu = 0; m_killed = 0; m_last_lsu = 0;
                    m_addr = s.ia; m_wen = 1'b0; m_wdata = '0; m_wmask = '0;
                end else if (e_lr) begin
                    m_busy = 1; m_sent = 0; m_lsu = 1; m_killed = 0; m_last_lsu = 1;
                    m_addr = s.la; m_wen = s.lw; m_wdata = s.lwd; m_wmask = s.lwm;
                end
            end else if (!m_sent) begin
                if (s.mrdy) m_sent = 1;
            end else if (s.mrv) begin
                m_busy = 0;
            end
        end
        cyc++;
    endtask

    task automatic do_reset(input int n);
        stim_t s;
        s = quiet();
        s.r = 1'b1;
        repeat (n) step(s);
    endtask

    initial begin
        stim_t s;
        model_reset();
        bus.ifu_req_valid = 0; bus.ifu_req_addr = '0; bus.ifu_flush = 0;
        bus.lsu_req_valid = 0; bus.lsu_req_addr = '0; bus.lsu_req_wen = 0;
        bus.lsu_req_wdata = '0; bus.lsu_req_wmask = '0;
        bus.mem_req_ready = 0; bus.mem_rsp_valid = 0; bus.mem_rsp_data = '0;

        // Lone fetch with zero-wait memory: accept, present, respond.
        do_reset(2);
        s = quiet(); step(s);
        ifu_rsp_cnt = 0; lsu_rsp_cnt = 0;
        s = quiet(); s.iv = 1; s.ia = 32'h8000_0000; s.mrdy = 1; step(s);
        s = quiet(); s.mrdy = 1; step(s);
        s = quiet(); s.mrv = 1; s.mrd = 64'h1122_3344_5566_7788; step(s);
        s = quiet(); step(s);
        check("t1_ifu_rsp_count", 64'(ifu_rsp_cnt), 64'd1);
        check("t1_lsu_rsp_count", 64'(lsu_rsp_cnt), 64'd0);

        // Both requesters held valid: grants alternate starting with LSU.
        do_reset(1);
        grant_log.delete();
        for (int i = 0; i < 18; i++) begin
            s = quiet(); s.iv = 1; s.ia = 32'h1000 + 32'(i); s.lv = 1; s.la = 32'h2000 + 32'(i);
            s.mrdy = 1; s.mrv = 1; s.mrd = {32'hCAFE_0000, 32'(i)};
            step(s);
        end
        check("t2_grant_count", 64'(grant_log.size()), 64'd6);
        for (int i = 0; i < grant_log.size() && i < 6; i++)
            check("t2_grant_order", 64'(grant_log[i]), (i % 2 == 0) ? 64'd2 : 64'd1);

        // Store with a 4-cycle memory stall; fields must stay put.
        s = quiet(); step(s);
        lsu_rsp_cnt = 0;
        s = quiet(); s.lv = 1; s.la = 32'h100; s.lw = 1; s.lwd = 64'hDEAD_BEEF; s.lwm = 8'h0F; step(s);
        s = quiet(); repeat (4) step(s);
        s = quiet(); s.mrdy = 1; step(s);
        s = quiet(); step(s);
        s = quiet(); s.mrv = 1; step(s);
        s = quiet(); step(s);
        check("t3_lsu_rsp_count", 64'(lsu_rsp_cnt), 64'd1);

        // Flush two cycles before the fetch response; then a clean fetch.
        ifu_rsp_cnt = 0;
        s = quiet(); s.iv = 1; s.ia = 32'h40; s.mrdy = 1; step(s);
        s = quiet(); s.mrdy = 1; step(s);
        s = quiet(); s.fl = 1; step(s);
        s = quiet(); step(s);
        s = quiet(); s.mrv = 1; s.mrd = 64'h0BAD; step(s);
        check("t4_flushed_rsp_count", 64'(ifu_rsp_cnt), 64'd0);
        s = quiet(); s.iv = 1; s.ia = 32'h80; s.mrdy = 1; step(s);
        s = quiet(); s.mrdy = 1; step(s);
        s = quiet(); s.mrv = 1; s.mrd = 64'h600D; step(s);
        check("t4_clean_rsp_count", 64'(ifu_rsp_cnt), 64'd1);

        // Flush blocks a same-cycle fetch; flush does not touch an LSU load.
        s = quiet(); s.iv = 1; s.ia = 32'hC0; s.fl = 1; step(s);
        lsu_rsp_cnt = 0;
        s = quiet(); s.lv = 1; s.la = 32'h200; s.mrdy = 1; step(s);
        s = quiet(); s.fl = 1; s.mrdy = 1; step(s);
        s = quiet(); s.fl = 1; s.mrv = 1; s.mrd = 64'h5555_AAAA; step(s);
        check("t5_lsu_rsp_count", 64'(lsu_rsp_cnt), 64'd1);

        // Reset while the request is presented; a late response is ignored.
        ifu_rsp_cnt = 0; lsu_rsp_cnt = 0;
        s = quiet(); s.iv = 1; s.ia = 32'h300; step(s);
        s = quiet(); s.r = 1; step(s);
        s = quiet(); s.mrv = 1; s.mrd = 64'h7777; step(s);
        s = quiet(); step(s);
        check("t6_rsp_after_reset", 64'(ifu_rsp_cnt + lsu_rsp_cnt), 64'd0);

        // Random traffic, including spurious responses and rare resets.
        for (int i = 0; i < 4000; i++) begin
            s.r    = ($urandom_range(199) == 0);
            s.iv   = ($urandom_range(9) < 6);
            s.ia   = $urandom;
            s.fl   = ($urandom_range(9) == 0);
            s.lv   = ($urandom_range(9) < 6);
            s.la   = $urandom;
            s.lw   = 1'($urandom_range(1));
            s.lwd  = {$urandom, $urandom};
            s.lwm  = 8'($urandom);
            s.mrdy = 1'($urandom_range(1));
            s.mrv  = ($urandom_range(9) < 4);
            s.mrd  = {$urandom, $urandom};
            step(s);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/core_mem_arb.md
Name: core_mem_arb

Overview:
- Two-requester arbiter sharing one memory port between the instruction fetch unit (IFU) and the EX-stage load/store unit (LSU).
- Grants one transaction at a time and holds the request stable until the memory accepts it.
- Routes the single response back to its owner.
- Drops fetch responses invalidated by a pipeline flush, so a redirected fetch never returns stale data.

Parameters:
- AW, 32, request address width
- DW, 64, data width
- MW, DW/8, byte write-mask width

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ifu_req_valid  in  1  IFU fetch request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_req_addr  in  AW  fetch address
- ifu_flush  in  1  pipeline flush; kills any outstanding or same-cycle IFU transaction
- ifu_rsp_valid  out  1  fetch data valid, one-cycle pulse
- ifu_rsp_data  out  DW  fetch data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_req_addr  in  AW  load/store address
- lsu_req_wen  in  1  1 = store, 0 = load
- lsu_req_wdata  in  DW  store data
- lsu_req_wmask  in  MW  store byte mask
- lsu_rsp_valid  out  1  load data, or store completion; one-cycle pulse
- lsu_rsp_data  out  DW  load data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  AW  latched address
- mem_req_wen  out  1  latched write enable
- mem_req_wdata  out  DW  latched write data
- mem_req_wmask  out  MW  latched mask
- mem_rsp_valid  in  1  memory response
- mem_rsp_data  in  DW  memory read data
- arb_busy  out  1  state != IDLE

Behaviour:
- States:
  - IDLE: arbitrate.
  - REQ: present the latched request.
  - RSP: await the response.
- Reset (synchronous, active-high):
  - state = IDLE; owner = IFU; rr_last = IFU; drop = 0.
  - All outputs 0, including mem_req_* fields.
  - Reset mid-transaction abandons it with no response pulse.
- IDLE:
  - Candidates are lsu_req_valid and (ifu_req_valid & ~ifu_flush).
  - Single candidate: it wins.
  - Both: the one that is not rr_last wins. The first tie after reset therefore goes to LSU.
  - Winner's req_ready = 1 combinationally in the same cycle; the loser's is 0.
  - On grant: latch addr, wen, wdata, wmask (IFU: wen = 0, wmask = 0, wdata = 0), owner, rr_last = winner, drop = 0; next state REQ.
  - No candidate: stay IDLE.
- REQ:
  - mem_req_valid = 1 with latched fields.
  - A request may not be withdrawn: fields are stable until mem_req_ready.
  - mem_req_ready = 1 → RSP in the next cycle.
- RSP:
  - On mem_rsp_valid, the owner's rsp_valid = 1 for that cycle, with rsp_data = mem_rsp_data; next state IDLE.
  - A store still waits for mem_rsp_valid; lsu_rsp_data is don't-care.
- Flush:
  - ifu_flush in REQ or RSP with owner = IFU sets drop.
  - The memory transaction still completes, but ifu_rsp_valid is suppressed.
  - A flush in the same cycle as mem_rsp_valid also suppresses.
  - Flush has no effect on an LSU-owned transaction.
- Non-owner rsp_valid is always 0. mem_rsp_valid outside RSP is ignored.
- Both req_ready outputs are 0 outside IDLE.
- Minimum round trip with zero-wait memory: accept in cycle 0, mem_req_valid in cycle 1, rsp in cycle 2, next grant in cycle 3.
- One outstanding transaction; no reordering.

Decomposition:
- Add to core_defines.v:
  - state encodings CORE_MARB_IDLE/REQ/RSP (2-bit)
  - owner codes CORE_MARB_OWN_IFU = 0, CORE_MARB_OWN_LSU = 1
- Sub-module core_mem_arb_rr: 2-way round-robin picker. Inputs: two valids and rr_last. Outputs: one-hot grant.

Test Plan:
1. Reset then IFU request alone, addr 0x8000_0000, mem ready immediately, rsp 0x1122334455667788 the cycle after accept → ifu_req_ready in cycle 0, mem_req_valid in cycle 1 with that addr, ifu_rsp_valid in cycle 2 with that data, lsu_rsp_valid never asserted.
2. Both valid right after reset → LSU granted first. Both held valid → IFU granted on the next IDLE. Grants alternate LSU, IFU, LSU over 6 transactions.
3. LSU store, addr 0x100, wdata 0xDEAD_BEEF, wmask 0x0F; mem_req_ready held low 4 cycles → mem_req_* fields constant for all 4 cycles; lsu_rsp_valid pulses once after mem_rsp_valid.
4. IFU transaction in RSP; ifu_flush pulses 2 cycles before mem_rsp_valid → no ifu_rsp_valid; state returns to IDLE; next IFU request is served normally.
5. ifu_flush asserted in IDLE together with ifu_req_valid (LSU idle) → ifu_req_ready = 0, state stays IDLE. ifu_flush during an LSU transaction → lsu_rsp_valid still delivered.
6. rst asserted while in REQ → state IDLE next cycle, mem_req_valid = 0, no rsp pulse; a late mem_rsp_valid is ignored.
